// File: rtl/tone_scheduler_if.sv
// tone_scheduler_if: key/play inputs and tone-generator outputs of the tone scheduler.
interface tone_scheduler_if;
    logic [6:0]  SW;
    logic        PLAY;
    logic        TONE_EN;
    logic [23:0] HALF_PERIOD;
    logic [2:0]  NOTE;
    logic        BUSY;
    logic        DONE;
    modport master (output SW, PLAY, input TONE_EN, HALF_PERIOD, NOTE, BUSY, DONE);
    modport slave  (input SW, PLAY, output TONE_EN, HALF_PERIOD, NOTE, BUSY, DONE);
endinterface

// File: rtl/tone_scheduler.sv
// tone_scheduler: arbitrates piano keys and a 16-step melody ROM into a tone divisor/enable.
// Define TONE_SCHED_LOOP_EN to repeat the melody until a key press or reset.
module tone_scheduler #(
    parameter int CLK_HZ      = 12000000,
    parameter int BEAT_CYCLES = 3000000,
    parameter int GAP_CYCLES  = 600000
) (
    input logic CLK_IN,
    input logic RST,
    tone_scheduler_if.slave bus
);
`ifdef TONE_SCHED_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, KEY, SEQ_NOTE, SEQ_GAP} state_t;
    localparam logic [23:0] DIV [8] = '{24'd0, 24'(CLK_HZ / 1046), 24'(CLK_HZ / 1174),
        24'(CLK_HZ / 1318), 24'(CLK_HZ / 1396), 24'(CLK_HZ / 1566), 24'(CLK_HZ / 1760),
        24'(CLK_HZ / 1974)};
    // {end, note, beats-1}
    localparam logic [5:0] ROM [16] = '{
        {1'b0, 3'd1, 2'd0}, {1'b0, 3'd2, 2'd0}, {1'b0, 3'd3, 2'd0}, {1'b0, 3'd4, 2'd0},
        {1'b0, 3'd5, 2'd0}, {1'b0, 3'd5, 2'd1}, {1'b0, 3'd6, 2'd0}, {1'b0, 3'd6, 2'd0},
        {1'b0, 3'd5, 2'd1}, {1'b0, 3'd4, 2'd0}, {1'b0, 3'd4, 2'd0}, {1'b0, 3'd3, 2'd0},
        {1'b0, 3'd3, 2'd0}, {1'b0, 3'd2, 2'd0}, {1'b1, 3'd1, 2'd0}, {1'b0, 3'd0, 2'd0}};
    localparam logic [23:0] GAP_LAST = 24'(GAP_CYCLES - 1);

    state_t      state, state_nxt;
    logic [6:0]  sw_s1, sw_s2;
    logic [7:0]  held;
    logic [2:0]  grant, grant_nxt;
    logic [3:0]  step, step_nxt;
    logic [23:0] cnt, dur;
    logic        any_key, note_end, gap_end, last;
    logic        tone_en_d, busy_d, done_d;
    logic [2:0]  note_d;
    logic        tone_en_q, busy_q, done_q;
    logic [2:0]  note_q;
    logic [23:0] hp_q;

    // held[0] is a permanent "no key" slot so grant 0 never counts as held
    assign held     = {~sw_s2, 1'b0};
    assign any_key  = |held;
    assign last     = ROM[step][5];
    assign dur      = (24'(ROM[step][1:0]) + 24'd1) * 24'(BEAT_CYCLES);
    assign note_end = cnt == dur - 24'd1;
    assign gap_end  = cnt == GAP_LAST;

    always_comb begin
        grant_nxt = 3'd0;
        for (int i = 6; i >= 0; i--)
            if (held[i+1]) grant_nxt = 3'(i + 1);
        if (held[grant]) grant_nxt = grant;
    end

    always_ff @(posedge CLK_IN or posedge RST)
        if (RST) begin
            state <= IDLE;
            step  <= 4'd0;
            cnt   <= 24'd0;
            grant <= 3'd0;
            sw_s1 <= '1;
            sw_s2 <= '1;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            cnt   <= (state_nxt != state || !busy_d) ? 24'd0 : cnt + 24'd1;
            grant <= grant_nxt;
            sw_s1 <= bus.SW;
            sw_s2 <= sw_s1;
        end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        if (any_key) state_nxt = KEY;
        else case (state)
            IDLE:     if (bus.PLAY) begin
                          state_nxt = SEQ_NOTE;
                          step_nxt  = 4'd0;
                      end
            KEY:      state_nxt = IDLE;
            SEQ_NOTE: if (note_end) state_nxt = SEQ_GAP;
            SEQ_GAP:  if (gap_end) begin
                          state_nxt = (last && !LOOP) ? IDLE : SEQ_NOTE;
                          step_nxt  = last ? 4'd0 : step + 4'd1;
                      end
            default:  state_nxt = IDLE;
        endcase
    end

    // outputs are decoded from the next state so they register alongside it
    always_comb begin
        note_d    = state_nxt == KEY ? grant_nxt : state_nxt == SEQ_NOTE ? ROM[step_nxt][4:2] : 3'd0;
        tone_en_d = note_d != 3'd0;
        busy_d    = state_nxt == SEQ_NOTE || state_nxt == SEQ_GAP;
        done_d    = state == SEQ_GAP && gap_end && last && !any_key;
    end

    always_ff @(posedge CLK_IN or posedge RST)
        if (RST) begin
            tone_en_q <= 1'b0;
            note_q    <= 3'd0;
            hp_q      <= 24'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tone_en_q <= tone_en_d;
            note_q    <= note_d;
            hp_q      <= DIV[note_d];
            busy_q    <= busy_d;
            done_q    <= done_d;
        end

    assign bus.TONE_EN     = tone_en_q;
    assign bus.NOTE        = note_q;
    assign bus.HALF_PERIOD = hp_q;
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
endmodule

// File: tb/tb_tone_scheduler.sv
// tb_tone_scheduler: key vector table, melody/abort/reset sequences and random traffic,
// every cycle checked against a timeline model of keys and melody.
module tb_tone_scheduler;
    localparam int BEAT = 10, GAP = 2, TOTAL = 17 * BEAT + 15 * GAP;
`ifdef TONE_SCHED_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    localparam int HP [8] = '{0, 11472, 10221, 9104, 8595, 7662, 6818, 6079};
    localparam int MN [15] = '{1, 2, 3, 4, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 1};
    localparam int MB [15] = '{1, 1, 1, 1, 1, 2, 1, 1, 2, 1, 1, 1, 1, 1, 1};

    typedef struct { logic [6:0] sw; int note; } vec_t;

    logic CLK_IN = 1'b0;
    logic RST = 1'b1;
    int n_chk = 0, n_fail = 0;
    logic [6:0] h1 = '1, h2 = '1;
    int g = 0, mode = 0, mt = 0;
    bit mdone = 0;

    tone_scheduler_if bus();
    tone_scheduler #(.CLK_HZ(12000000), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP))
        dut (.CLK_IN(CLK_IN), .RST(RST), .bus(bus));

    always #5 CLK_IN = ~CLK_IN;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // note playing t clocks into the melody, 0 during a gap
    function automatic int mel_note(input int t);
        int r = t;
        for (int i = 0; i < 15; i++) begin
            if (r < MB[i] * BEAT) return MN[i];
            r -= MB[i] * BEAT;
            if (r < GAP) return 0;
            r -= GAP;
        end
        return 0;
    endfunction

    task automatic model_reset();
        h1 = '1; h2 = '1; g = 0; mode = 0; mt = 0; mdone = 0;
    endtask

    // mode: 0 idle, 1 key, 2 melody (mt = clocks since melody start)
    task automatic model_edge(input logic [6:0] sw, input logic play);
        logic [6:0] p;
        int ng;
        p = ~h2;
        ng = 0;
        for (int i = 6; i >= 0; i--) if (p[i]) ng = i + 1;
        if (g != 0 && p[g-1]) ng = g;
        g = ng;
        h2 = h1;
        h1 = sw;
        mdone = 0;
        if (p != 0) mode = 1;
        else if (mode == 1) mode = 0;
        else if (mode == 2) begin
            mt++;
            if (mt == TOTAL) begin
                mdone = 1;
                mt = 0;
                if (!LOOP) mode = 0;
            end
        end else if (play) begin
            mode = 2;
            mt = 0;
        end
    endtask

    function automatic logic [31:0] exp_vec();
        int n;
        n = mode == 1 ? g : mode == 2 ? mel_note(mt) : 0;
        return {2'b0, n != 0, mode == 2, mdone, 3'(n), 24'(HP[n])};
    endfunction

    function automatic logic [31:0] out_vec();
        return {2'b0, bus.TONE_EN, bus.BUSY, bus.DONE, bus.NOTE, bus.HALF_PERIOD};
    endfunction

    task automatic tick();
        @(posedge CLK_IN);
        if (RST) model_reset();
        else model_edge(bus.SW, bus.PLAY);
        #1;
        check("model", out_vec(), exp_vec());
    endtask

    initial begin
        vec_t tv [12];
        int segs, silent, prev_en, prev_note, c;
        int sn [20], sl [20];
        tv[0]  = '{7'b1111110, 1};
        tv[1]  = '{7'b1111111, 0};
        tv[2]  = '{7'b1101111, 5};
        tv[3]  = '{7'b1101101, 5};
        tv[4]  = '{7'b1111101, 2};
        tv[5]  = '{7'b0111111, 7};
        tv[6]  = '{7'b0111110, 7};
        tv[7]  = '{7'b1111110, 1};
        tv[8]  = '{7'b1111011, 3};
        tv[9]  = '{7'b1110111, 4};
        tv[10] = '{7'b1011111, 6};
        tv[11] = '{7'b1111111, 0};
        bus.SW = '1;
        bus.PLAY = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        check("reset_outputs", out_vec(), 32'd0);

        // key table: value must appear exactly on the 3rd edge
        prev_note = 0;
        for (int i = 0; i < 12; i++) begin
            bus.SW = tv[i].sw;
            tick();
            tick();
            check($sformatf("vec%0d_early", i), bus.NOTE, prev_note);
            tick();
            check($sformatf("vec%0d_note", i), bus.NOTE, tv[i].note);
            check($sformatf("vec%0d_hp", i), bus.HALF_PERIOD, HP[tv[i].note]);
            check($sformatf("vec%0d_en", i), bus.TONE_EN, tv[i].note != 0);
            tick();
            prev_note = tv[i].note;
        end

        // full melody with a PLAY re-pulse in the middle
        bus.PLAY = 1'b1;
        tick();
        bus.PLAY = 1'b0;
        check("play_busy", bus.BUSY, 1);
        segs = 0; silent = 0; prev_en = 0;
        for (c = 0; c < 400 && !bus.DONE; c++) begin
            if (bus.TONE_EN) begin
                if (!prev_en && segs < 20) begin
                    sn[segs] = bus.NOTE;
                    sl[segs] = 0;
                    segs++;
                end
                if (segs > 0) sl[segs-1]++;
            end else if (bus.BUSY) silent++;
            prev_en = bus.TONE_EN;
            bus.PLAY = c == 77;
            tick();
        end
        bus.PLAY = 1'b0;
        check("mel_done", bus.DONE, 1);
        check("mel_segs", segs, 15);
        for (int i = 0; i < 15 && i < segs; i++) begin
            check($sformatf("mel_note%0d", i), sn[i], MN[i]);
            check($sformatf("mel_len%0d", i), sl[i], MB[i] * BEAT);
        end
        check("mel_gaps", silent, 15 * GAP);
        check("mel_end_busy", bus.BUSY, LOOP);
        check("mel_end_note", bus.NOTE, LOOP ? 1 : 0);
        tick();
        check("done_pulse", bus.DONE, 0);
        bus.SW = 7'b1111110;
        repeat (4) tick();
        bus.SW = '1;
        repeat (4) tick();

        // key abort at step 3
        bus.PLAY = 1'b1;
        tick();
        bus.PLAY = 1'b0;
        for (c = 0; c < 100 && bus.NOTE != 3'd4; c++) tick();
        check("abort_reach", bus.NOTE, 4);
        bus.SW = 7'b0111111;
        tick();
        tick();
        check("abort_early_busy", bus.BUSY, 1);
        tick();
        check("abort_note", bus.NOTE, 7);
        check("abort_busy", bus.BUSY, 0);
        check("abort_done", bus.DONE, 0);
        check("abort_hp", bus.HALF_PERIOD, 6079);
        bus.SW = '1;
        repeat (3) tick();
        check("abort_idle", out_vec(), 32'd0);
        tick();

        // asynchronous reset mid-note
        bus.PLAY = 1'b1;
        tick();
        bus.PLAY = 1'b0;
        repeat (15) tick();
        check("rst_pre_note", bus.NOTE, 2);
        #2 RST = 1'b1;
        #1 check("rst_async", out_vec(), 32'd0);
        tick();
        tick();
        RST = 1'b0;
        repeat (3) tick();
        check("rst_idle", out_vec(), 32'd0);

        // random keys and PLAY pulses
        for (int n = 0; n < 40; n++) begin
            int hold;
            hold = $urandom_range(1, 250);
            bus.SW = $urandom_range(0, 9) < 6 ? 7'h7F :
                7'h7F & ~(7'd1 << $urandom_range(0, 6)) & ~(7'd1 << $urandom_range(0, 6));
            for (int k = 0; k < hold; k++) begin
                bus.PLAY = $urandom_range(0, 15) == 0;
                tick();
            end
            bus.PLAY = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
